// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - host stream and instruction-memory write bundle for program_loader
interface program_loader_if #(
  parameter int PC_WIDTH          = 4,
  parameter int INSTRUCTION_WIDTH = 16
);
  logic                         start;
  logic [7:0]                   inData;
  logic                         inValid;
  logic                         inReady;
  logic                         writeEnable;
  logic [PC_WIDTH-1:0]          writeAddress;
  logic [INSTRUCTION_WIDTH-1:0] writeData;
  logic                         cpuHold;
  logic                         loadDone;
  logic                         loadError;

  modport master (
    output start, inData, inValid,
    input  inReady, writeEnable, writeAddress, writeData, cpuHold, loadDone, loadError
  );

  modport slave (
    input  start, inData, inValid,
    output inReady, writeEnable, writeAddress, writeData, cpuHold, loadDone, loadError
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader into instruction memory (optional CHECKSUM_EN)
module program_loader #(
  parameter int PC_WIDTH          = 4,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic               clock,
  input  logic               resetN,
  program_loader_if.slave    bus
);

  localparam int HI_WIDTH  = INSTRUCTION_WIDTH - 8;
  localparam int MAX_WORDS = 2 ** PC_WIDTH;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HEADER = 3'd1;
  localparam logic [2:0] HIGH   = 3'd2;
  localparam logic [2:0] LOW    = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
`ifdef CHECKSUM_EN
  localparam logic [2:0] CHECK  = 3'd5;
`endif
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;

  logic [2:0]                   state;
  logic [PC_WIDTH-1:0]          word_idx;
  logic [7:0]                   remaining;
  logic [HI_WIDTH-1:0]          hi_byte;
  logic [PC_WIDTH-1:0]          write_address;
  logic [INSTRUCTION_WIDTH-1:0] write_data;
  logic                         ready;
  logic                         xfer;
`ifdef CHECKSUM_EN
  logic [7:0]                   checksum;
`endif

  // Ready is a pure function of state so it never loops back through inValid.
  always_comb begin
    ready = 1'b0;
    case (state)
      HEADER, HIGH, LOW: ready = 1'b1;
`ifdef CHECKSUM_EN
      CHECK:             ready = 1'b1;
`endif
      default:           ready = 1'b0;
    endcase
  end

  assign xfer = ready && bus.inValid;

  // Load sequencer: header count, high/low bytes per word, one write cycle per word.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      word_idx      <= '0;
      remaining     <= '0;
      hi_byte       <= '0;
      write_address <= '0;
      write_data    <= '0;
`ifdef CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            state     <= HEADER;
            word_idx  <= '0;
            remaining <= '0;
`ifdef CHECKSUM_EN
            checksum  <= '0;
`endif
          end
        end
        HEADER: begin
          if (xfer) begin
            if (bus.inData == 8'd0 || int'(bus.inData) > MAX_WORDS) begin
              state <= ERROR;
            end else begin
              state     <= HIGH;
              remaining <= bus.inData;
            end
`ifdef CHECKSUM_EN
            checksum <= checksum ^ bus.inData;
`endif
          end
        end
        HIGH: begin
          if (xfer) begin
            hi_byte <= HI_WIDTH'(bus.inData);
            state   <= LOW;
`ifdef CHECKSUM_EN
            checksum <= checksum ^ bus.inData;
`endif
          end
        end
        LOW: begin
          // The whole word and its address update together so both hold steady outside WRITE.
          if (xfer) begin
            write_data    <= {hi_byte, bus.inData};
            write_address <= word_idx;
            state         <= WRITE;
`ifdef CHECKSUM_EN
            checksum <= checksum ^ bus.inData;
`endif
          end
        end
        WRITE: begin
          word_idx  <= word_idx + PC_WIDTH'(1);
          remaining <= remaining - 8'd1;
          if (remaining == 8'd1) begin
`ifdef CHECKSUM_EN
            state <= CHECK;
`else
            state <= DONE;
`endif
          end else begin
            state <= HIGH;
          end
        end
`ifdef CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            state <= (bus.inData == checksum) ? DONE : ERROR;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inReady      = ready;
  assign bus.writeEnable  = (state == WRITE);
  assign bus.writeAddress = write_address;
  assign bus.writeData    = write_data;
  assign bus.cpuHold      = (state != DONE);
  assign bus.loadDone     = (state == DONE);
  assign bus.loadError    = (state == ERROR);

endmodule
